rx_deframer: RTL and testbench
==============================

Name: rx_deframer

Overview:
- Sits directly downstream of transceiver_top.
- Consumes the recovered serial bit `q`, qualified by the `done` strobe, and hunts for a sync word.
- Once locked, it deserializes a length-prefixed frame into bytes and checks an XOR checksum.
- It presents payload bytes with valid/last flags and pulses a pass/fail status per frame for the byte-level consumer.

Parameters:
- SYNC_WORD, 8'hD5, frame sync pattern, MSB-first, must be nonzero.
- MAX_LEN, 16, largest accepted payload length in bytes (1..255).
- TIMEOUT, 64, clk cycles without bit_valid tolerated mid-frame before abort (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  reset, synchronous, active-high.
- bit_in  in  1  recovered bit (transceiver q).
- bit_valid  in  1  one-cycle strobe marking bit_in valid (transceiver done).
- byte_data  out  8  payload byte.
- byte_valid  out  1  one-cycle pulse, byte_data valid.
- byte_last  out  1  high with byte_valid on the final payload byte.
- frame_ok  out  1  one-cycle pulse, checksum matched.
- frame_err  out  1  one-cycle pulse, frame rejected (bad checksum, length > MAX_LEN, or timeout).
- locked  out  1  high while in any state other than HUNT.

Behaviour:
- Reset (arst high at a clk edge):
  - All outputs 0.
  - State HUNT; shift register, bit count, fill count, checksum and timeout counter cleared.
  - Reset dominates every other event, mid-frame included; no status pulse is emitted for an aborted frame.
- Bit order: MSB first in all fields. A byte completes on the 8th bit_valid of its field.
- Register updates happen only on cycles with bit_valid=1, except for the timeout counter.
- HUNT:
  - Each valid bit shifts into an 8-bit history register; a fill counter saturates at 8.
  - Match when fill=8 and the history after the shift equals SYNC_WORD.
  - On match, go to LEN and clear the bit count and checksum.
  - On entering HUNT from any state, history and fill are cleared, so a sync needs 8 fresh bits.
- LEN: collect 8 bits into the length register.
  - Length > MAX_LEN: pulse frame_err next cycle, go to HUNT.
  - Length = 0: go to CHECK.
  - Otherwise go to PAYLOAD with the remaining-byte count set to the length.
- PAYLOAD:
  - On each completed byte, register byte_data and pulse byte_valid on the following cycle (latency 1 clk after the completing bit_valid).
  - checksum ^= byte; decrement the remaining count.
  - byte_last=1 when the remaining count was 1; then go to CHECK.
- CHECK: collect 8 bits.
  - If the received byte equals the running checksum (0x00 for length 0), pulse frame_ok next cycle, else pulse frame_err next cycle.
  - Return to HUNT in either case.
- Timeout:
  - In LEN, PAYLOAD and CHECK, a counter increments each clk with bit_valid=0 and clears on bit_valid=1.
  - When it reaches TIMEOUT: pulse frame_err next cycle and go to HUNT. Partial bytes are discarded and no byte_valid is emitted.
  - The counter is idle and held at 0 in HUNT.
- Pulse rules:
  - byte_valid, frame_ok and frame_err are never high for more than 1 cycle.
  - frame_ok and frame_err are mutually exclusive.
  - byte_data holds its last value between pulses.
- Back-to-back frames: a sync may start on the bit_valid immediately following the checksum's last bit; no gap is required.
- bit_valid may be high on consecutive cycles; full throughput is 1 bit per clk.
- locked rises the cycle after a sync match and falls the cycle after the exit to HUNT.

Test Plan:
- Reset mid-PAYLOAD (arst high 1 cycle after 2nd payload byte) -> all outputs 0, locked=0, no frame_err; a subsequent clean frame is received correctly.
- Bitstream D5 03 11 22 44 77 with bit_valid every 4 clk -> byte_valid pulses carrying 11, 22, 44; byte_last only with 44; frame_ok one pulse 1 clk after the last checksum bit; no frame_err.
- Same frame with checksum 76 -> three payload bytes delivered, frame_err pulse, frame_ok stays 0, locked drops.
- Random noise containing no D5 window, then D5 00 00 at 1 bit/clk -> no byte_valid, frame_ok pulse, locked high exactly for LEN+CHECK duration.
- Length byte 0x11 (17 > MAX_LEN=16) -> frame_err 1 clk after 8th length bit, no byte_valid, back in HUNT; the next D5 frame is accepted.
- Sync + length 02 + 1 payload byte, then bit_valid held low for 64 clk -> byte_valid once, frame_err on timeout, locked=0; two back-to-back valid frames afterwards -> two frame_ok pulses.

Source files
------------

// File: rtl/rx_deframer_if.sv
// Bit-stream in / byte-stream out bundle between the transceiver-side
// bit source and the frame deserializer.
interface rx_deframer_if;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       frame_ok;
    logic       frame_err;
    logic       locked;

    modport master (
        output bit_in,
        output bit_valid,
        input  byte_data,
        input  byte_valid,
        input  byte_last,
        input  frame_ok,
        input  frame_err,
        input  locked
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output byte_data,
        output byte_valid,
        output byte_last,
        output frame_ok,
        output frame_err,
        output locked
    );
endinterface

// File: rtl/rx_deframer.sv
// Hunts for a sync word in a qualified serial bit stream, then deserializes a
// length-prefixed frame into bytes and verifies its trailing XOR checksum.
module rx_deframer #(
    parameter logic [7:0] SYNC_WORD = 8'hD5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          arst,
    rx_deframer_if.slave  rx
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    state_t         r_state;
    logic [7:0]     r_shift;
    logic [3:0]     r_fill;
    logic [2:0]     r_bitCnt;
    logic [7:0]     r_remain;
    logic [7:0]     r_csum;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_byteData;
    logic           r_byteValid;
    logic           r_byteLast;
    logic           r_frameOk;
    logic           r_frameErr;

    state_t         w_state;
    logic [7:0]     w_shift;
    logic [3:0]     w_fill;
    logic [2:0]     w_bitCnt;
    logic [7:0]     w_remain;
    logic [7:0]     w_csum;
    logic [TW-1:0]  w_timer;
    logic [7:0]     w_byteData;
    logic           w_byteValid;
    logic           w_byteLast;
    logic           w_frameOk;
    logic           w_frameErr;

    logic [7:0]     w_shiftIn;
    logic           w_byteDone;
    logic [TW-1:0]  w_timerInc;

    assign w_shiftIn  = {r_shift[6:0], rx.bit_in};
    assign w_byteDone = (r_bitCnt == 3'd7);
    assign w_timerInc = r_timer + 1'b1;

    // Next-state and pulse decode; the shift register doubles as the sync
    // history in HUNT and as the field accumulator once locked.
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_fill      = r_fill;
        w_bitCnt    = r_bitCnt;
        w_remain    = r_remain;
        w_csum      = r_csum;
        w_timer     = r_timer;
        w_byteData  = r_byteData;
        w_byteValid = 1'b0;
        w_byteLast  = 1'b0;
        w_frameOk   = 1'b0;
        w_frameErr  = 1'b0;

        case (r_state)
            ST_HUNT: begin
                w_timer = '0;
                if (rx.bit_valid) begin
                    w_shift = w_shiftIn;
                    if (r_fill != 4'd8) begin
                        w_fill = r_fill + 4'd1;
                    end
                    if ((r_fill >= 4'd7) && (w_shiftIn == SYNC_WORD)) begin
                        w_state  = ST_LEN;
                        w_bitCnt = '0;
                        w_csum   = '0;
                    end
                end
            end

            default: begin
                if (rx.bit_valid) begin
                    w_timer  = '0;
                    w_shift  = w_shiftIn;
                    w_bitCnt = r_bitCnt + 3'd1;
                    if (w_byteDone) begin
                        case (r_state)
                            ST_LEN: begin
                                if (w_shiftIn > 8'(MAX_LEN)) begin
                                    w_frameErr = 1'b1;
                                    w_state    = ST_HUNT;
                                end else if (w_shiftIn == 8'd0) begin
                                    w_state = ST_CHECK;
                                end else begin
                                    w_remain = w_shiftIn;
                                    w_state  = ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                w_byteData  = w_shiftIn;
                                w_byteValid = 1'b1;
                                w_csum      = r_csum ^ w_shiftIn;
                                w_remain    = r_remain - 8'd1;
                                if (r_remain == 8'd1) begin
                                    w_byteLast = 1'b1;
                                    w_state    = ST_CHECK;
                                end
                            end
                            default: begin
                                if (w_shiftIn == r_csum) begin
                                    w_frameOk = 1'b1;
                                end else begin
                                    w_frameErr = 1'b1;
                                end
                                w_state = ST_HUNT;
                            end
                        endcase
                    end
                end else if (w_timerInc == TW'(TIMEOUT)) begin
                    w_frameErr = 1'b1;
                    w_state    = ST_HUNT;
                end else begin
                    w_timer = w_timerInc;
                end
            end
        endcase

        // Returning to HUNT forgets all partial state so a new sync needs 8 fresh bits.
        if ((w_state == ST_HUNT) && (r_state != ST_HUNT)) begin
            w_shift  = '0;
            w_fill   = '0;
            w_bitCnt = '0;
            w_timer  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state     <= ST_HUNT;
            r_shift     <= '0;
            r_fill      <= '0;
            r_bitCnt    <= '0;
            r_remain    <= '0;
            r_csum      <= '0;
            r_timer     <= '0;
            r_byteData  <= '0;
            r_byteValid <= 1'b0;
            r_byteLast  <= 1'b0;
            r_frameOk   <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_fill      <= w_fill;
            r_bitCnt    <= w_bitCnt;
            r_remain    <= w_remain;
            r_csum      <= w_csum;
            r_timer     <= w_timer;
            r_byteData  <= w_byteData;
            r_byteValid <= w_byteValid;
            r_byteLast  <= w_byteLast;
            r_frameOk   <= w_frameOk;
            r_frameErr  <= w_frameErr;
        end
    end

    assign rx.byte_data  = r_byteData;
    assign rx.byte_valid = r_byteValid;
    assign rx.byte_last  = r_byteLast;
    assign rx.frame_ok   = r_frameOk;
    assign rx.frame_err  = r_frameErr;
    assign rx.locked     = (r_state != ST_HUNT);

endmodule

// File: tb/tb_rx_deframer.sv
// Directed table-driven bench for rx_deframer plus hand-written sequences for
// reset mid-frame, timeout abort and back-to-back frames.
module tb_rx_deframer;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic arst;

    rx_deframer_if bus();

    rx_deframer #(
        .SYNC_WORD (8'hD5),
        .MAX_LEN   (16),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .rx   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] stream;
        int           nBytes;
        int           gap;
        bit           noise;
        int           expCount;
        int           expOk;
        int           expErr;
    } vec_t;

    vec_t vecs[7];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    logic [7:0] gotData[$];
    logic       gotLast[$];
    int okCnt = 0;
    int errCnt = 0;
    int okStamp = -1;
    int errStamp = -1;
    int lockedCnt = 0;
    int lastBitCyc = 0;
    logic prevBv = 1'b0;
    logic prevOk = 1'b0;
    logic prevErr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Output monitor: records pulses with the cycle stamp of the edge that produced them.
    always @(negedge clk) begin
        if (bus.byte_valid) begin
            gotData.push_back(bus.byte_data);
            gotLast.push_back(bus.byte_last);
        end
        if (bus.frame_ok) begin
            okCnt++;
            okStamp = cyc;
        end
        if (bus.frame_err) begin
            errCnt++;
            errStamp = cyc;
        end
        if (bus.locked === 1'b1) lockedCnt++;
        if (bus.frame_ok || bus.frame_err)
            checkOutput("ok_err_exclusive", 32'(bus.frame_ok && bus.frame_err), 0);
        if (bus.byte_valid || bus.frame_ok || bus.frame_err)
            checkOutput("pulse_width", 32'((bus.byte_valid && prevBv) || (bus.frame_ok && prevOk) ||
                                            (bus.frame_err && prevErr)), 0);
        if (bus.byte_last)
            checkOutput("last_without_valid", 32'(bus.byte_valid), 1);
        prevBv  = bus.byte_valid;
        prevOk  = bus.frame_ok;
        prevErr = bus.frame_err;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendBit(input logic b, input int gap);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        lastBitCyc    = cyc + 1;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) sendBit(v[i], gap);
    endtask

    task automatic clearMon();
        @(posedge clk);
        #1;
        gotData.delete();
        gotLast.delete();
        okCnt     = 0;
        errCnt    = 0;
        okStamp   = -1;
        errStamp  = -1;
        lockedCnt = 0;
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] b;
        clearMon();
        if (v.noise) begin
            sendByte(8'hFF, 1);
            sendByte(8'h00, 1);
            sendByte(8'h33, 1);
            sendByte(8'h00, 1);
        end
        for (int i = 0; i < v.nBytes; i++) begin
            b = v.stream[159 - 8*i -: 8];
            sendByte(b, v.gap);
        end
        settle(4);
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        logic [7:0] exp;
        checkOutput($sformatf("v%0d_byte_count", idx), gotData.size(), v.expCount);
        for (int k = 0; k < v.expCount && k < gotData.size(); k++) begin
            exp = v.stream[159 - 8*(k + 2) -: 8];
            checkOutput($sformatf("v%0d_data%0d", idx, k), gotData[k], exp);
            checkOutput($sformatf("v%0d_last%0d", idx, k), gotLast[k], 32'(k == v.expCount - 1));
        end
        checkOutput($sformatf("v%0d_ok_count", idx), okCnt, v.expOk);
        checkOutput($sformatf("v%0d_err_count", idx), errCnt, v.expErr);
        if (v.expOk != 0)
            checkOutput($sformatf("v%0d_ok_latency", idx), okStamp, lastBitCyc);
        if (v.expErr != 0)
            checkOutput($sformatf("v%0d_err_latency", idx), errStamp, lastBitCyc);
        checkOutput($sformatf("v%0d_locked_cycles", idx), lockedCnt, 8 * (v.nBytes - 1) * v.gap);
        checkOutput($sformatf("v%0d_locked_after", idx), bus.locked, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_byte_data"}, bus.byte_data, 0);
        checkOutput({tag, "_byte_valid"}, bus.byte_valid, 0);
        checkOutput({tag, "_byte_last"}, bus.byte_last, 0);
        checkOutput({tag, "_frame_ok"}, bus.frame_ok, 0);
        checkOutput({tag, "_frame_err"}, bus.frame_err, 0);
        checkOutput({tag, "_locked"}, bus.locked, 0);
    endtask

    initial begin
        vecs[0] = '{stream: {8'hD5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77, 112'h0},
                    nBytes: 6, gap: 4, noise: 1'b0, expCount: 3, expOk: 1, expErr: 0};
        vecs[1] = '{stream: {8'hD5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h76, 112'h0},
                    nBytes: 6, gap: 4, noise: 1'b0, expCount: 3, expOk: 0, expErr: 1};
        vecs[2] = '{stream: {8'hD5, 8'h00, 8'h00, 136'h0},
                    nBytes: 3, gap: 1, noise: 1'b1, expCount: 0, expOk: 1, expErr: 0};
        vecs[3] = '{stream: {8'hD5, 8'h11, 144'h0},
                    nBytes: 2, gap: 2, noise: 1'b0, expCount: 0, expOk: 0, expErr: 1};
        vecs[4] = '{stream: {8'hD5, 8'h01, 8'hA5, 8'hA5, 128'h0},
                    nBytes: 4, gap: 1, noise: 1'b0, expCount: 1, expOk: 1, expErr: 0};
        vecs[5] = '{stream: {8'hD5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10, 8'h00},
                    nBytes: 19, gap: 1, noise: 1'b0, expCount: 16, expOk: 1, expErr: 0};
        vecs[6] = '{stream: {8'hD5, 8'h02, 8'hFF, 8'h0F, 8'hF0, 120'h0},
                    nBytes: 5, gap: 3, noise: 1'b0, expCount: 2, expOk: 1, expErr: 0};

        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        arst          = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        arst = 1'b0;

        // Reset one cycle after the second payload byte of a 4-byte frame.
        $display("[TB] reset mid-payload");
        clearMon();
        sendByte(8'hD5, 1);
        sendByte(8'h04, 1);
        sendByte(8'hAA, 1);
        sendByte(8'hBB, 1);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        checkAllZero("midreset");
        settle(TIMEOUT + 8);
        checkOutput("midreset_byte_count", gotData.size(), 2);
        if (gotData.size() == 2) begin
            checkOutput("midreset_data0", gotData[0], 8'hAA);
            checkOutput("midreset_data1", gotData[1], 8'hBB);
            checkOutput("midreset_last1", gotLast[1], 0);
        end
        checkOutput("midreset_err_count", errCnt, 0);
        checkOutput("midreset_ok_count", okCnt, 0);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
        end

        // Timeout after one payload byte of a 2-byte frame.
        $display("[TB] timeout abort");
        clearMon();
        sendByte(8'hD5, 1);
        sendByte(8'h02, 1);
        sendByte(8'h5A, 1);
        settle(TIMEOUT + 8);
        checkOutput("timeout_byte_count", gotData.size(), 1);
        if (gotData.size() == 1) checkOutput("timeout_data0", gotData[0], 8'h5A);
        checkOutput("timeout_err_count", errCnt, 1);
        checkOutput("timeout_err_stamp", errStamp, lastBitCyc + TIMEOUT);
        checkOutput("timeout_ok_count", okCnt, 0);
        checkOutput("timeout_locked", bus.locked, 0);

        // Two frames with no gap between checksum and the next sync.
        $display("[TB] back-to-back frames");
        clearMon();
        sendByte(8'hD5, 1);
        sendByte(8'h01, 1);
        sendByte(8'h3C, 1);
        sendByte(8'h3C, 1);
        sendByte(8'hD5, 1);
        sendByte(8'h00, 1);
        sendByte(8'h00, 1);
        settle(4);
        checkOutput("b2b_ok_count", okCnt, 2);
        checkOutput("b2b_err_count", errCnt, 0);
        checkOutput("b2b_byte_count", gotData.size(), 1);
        if (gotData.size() == 1) begin
            checkOutput("b2b_data0", gotData[0], 8'h3C);
            checkOutput("b2b_last0", gotLast[0], 1);
        end
        checkOutput("b2b_ok_stamp", okStamp, lastBitCyc);
        checkOutput("b2b_locked_cycles", lockedCnt, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
